// File: rtl/sha256_controller.sv
// Sequencing controller for multi-block SHA-256: feeds padded blocks to a hash_engine,
// chains each block's result into the next and returns the final digest.
module sha256_controller #(
    parameter int unsigned TIMEOUT = 128,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             blk_last,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [255:0]     digest,
    output logic             eng_load,
    output logic             eng_clear_hash,
    output logic [511:0]     eng_block,
    output logic [255:0]     eng_prev_hash,
    input  logic [255:0]     eng_hash_out,
    input  logic             eng_done,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] blk_count
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [2:0] {StIdle, StLoad, StArm, StRun, StOut} state_e;

    state_e             state_q, state_d;
    logic [511:0]       block_q;
    logic [255:0]       chain_q;
    logic               last_q;
    logic               first_q;
    logic               error_q;
    logic [CNT_W-1:0]   count_q;
    logic [TMR_W-1:0]   tmr_q;

    logic accept;
    logic done_hit;
    logic timed_out;

    assign accept    = (state_q == StIdle) && blk_valid;
    assign done_hit  = (state_q == StRun) && eng_done;
    // Counter started at zero in ARM, so this is the TIMEOUT-th cycle since ARM was entered.
    assign timed_out = (state_q == StRun) && !eng_done && (tmr_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (blk_valid) state_d = StLoad;
            StLoad: state_d = StArm;
            // Engine's done flag is still stale here; it only clears one cycle after load.
            StArm:  state_d = StRun;
            StRun: begin
                if (eng_done) begin
                    state_d = last_q ? StOut : StIdle;
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StOut:  if (dig_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        blk_ready      = 1'b0;
        busy           = 1'b1;
        eng_load       = 1'b0;
        eng_clear_hash = 1'b0;
        dig_valid      = 1'b0;
        unique case (state_q)
            StIdle: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
            end
            StLoad: begin
                eng_load       = 1'b1;
                eng_clear_hash = first_q;
            end
            StOut:  dig_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            block_q <= '0;
            chain_q <= IV;
            last_q  <= 1'b0;
            first_q <= 1'b1;
            error_q <= 1'b0;
            count_q <= '0;
            tmr_q   <= '0;
        end else begin
            if (accept) begin
                block_q <= blk_data;
                last_q  <= blk_last;
                if (first_q) begin
                    chain_q <= IV;
                    count_q <= '0;
                    error_q <= 1'b0;
                end
            end
            if (done_hit) begin
                chain_q <= eng_hash_out;
                if (count_q != '1) count_q <= count_q + CNT_W'(1);
                first_q <= 1'b0;
            end
            // Abandon the message; the next accepted block restarts from the IV.
            if (timed_out) begin
                error_q <= 1'b1;
                first_q <= 1'b1;
            end
            if ((state_q == StOut) && dig_ready) first_q <= 1'b1;
            if (state_q == StLoad) begin
                tmr_q <= '0;
            end else if ((state_q == StArm) || (state_q == StRun)) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end
        end
    end

    assign eng_block     = block_q;
    assign eng_prev_hash = chain_q;
    assign digest        = chain_q;
    assign error         = error_q;
    assign blk_count     = count_q;

endmodule

// File: tb/tb_sha256_controller.sv
// Bench for sha256_controller: behavioural SHA-256 engine model, known-answer and random
// messages, stalls, mid-run reset, plus a stubbed-engine instance for timeout and stale done.
module tb_sha256_controller;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam int NMSG = 6;

    typedef struct packed {
        int                 nblk;
        logic [2:0][511:0]  blk;
        logic [255:0]       exp;
    } msg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic blk_valid, blk_ready, blk_last, dig_valid, dig_ready;
    logic [511:0] blk_data, eng_block;
    logic [255:0] digest, eng_prev_hash, eng_hash_out;
    logic eng_load, eng_clear_hash, eng_done, busy, error;
    logic [15:0] blk_count;

    logic blk_valid2, blk_ready2, blk_last2, dig_valid2, dig_ready2;
    logic [511:0] blk_data2, eng_block2;
    logic [255:0] digest2, eng_prev_hash2, eng_hash_out2;
    logic eng_load2, eng_clear_hash2, eng_done2, busy2, error2;
    logic [15:0] blk_count2;

    sha256_controller dut (
        .clk(clk), .n_rst(n_rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_last(blk_last), .dig_valid(dig_valid), .dig_ready(dig_ready),
        .digest(digest), .eng_load(eng_load), .eng_clear_hash(eng_clear_hash),
        .eng_block(eng_block), .eng_prev_hash(eng_prev_hash), .eng_hash_out(eng_hash_out),
        .eng_done(eng_done), .busy(busy), .error(error), .blk_count(blk_count)
    );

    sha256_controller #(.TIMEOUT(16)) dut2 (
        .clk(clk), .n_rst(n_rst), .blk_valid(blk_valid2), .blk_ready(blk_ready2),
        .blk_data(blk_data2), .blk_last(blk_last2), .dig_valid(dig_valid2),
        .dig_ready(dig_ready2), .digest(digest2), .eng_load(eng_load2),
        .eng_clear_hash(eng_clear_hash2), .eng_block(eng_block2),
        .eng_prev_hash(eng_prev_hash2), .eng_hash_out(eng_hash_out2), .eng_done(eng_done2),
        .busy(busy2), .error(error2), .blk_count(blk_count2)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h_in,
                                                  input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int j = 0; j < 8; j++) v[j] = h_in[255 - 32*j -: 32];
        for (int i = 0; i < 64; i++) begin
            s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
            t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
            t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = h_in[255 - 32*j -: 32] + v[j];
        return res;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Engine model: result computed at load, done after eng_lat cycles, stale done
    // lingers for one cycle after load.
    int   eng_lat = 64;
    int   eng_lat_q, eng_cnt;
    logic eng_run, eng_clr;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            eng_done     <= 1'b0;
            eng_run      <= 1'b0;
            eng_clr      <= 1'b0;
            eng_cnt      <= 0;
            eng_hash_out <= '0;
        end else if (eng_load) begin
            eng_hash_out <= sha_compress(eng_prev_hash, eng_block);
            eng_cnt      <= 0;
            eng_run      <= 1'b1;
            eng_clr      <= 1'b1;
            eng_lat_q    <= eng_lat;
        end else begin
            if (eng_clr) begin
                eng_done <= 1'b0;
                eng_clr  <= 1'b0;
            end
            if (eng_run) begin
                eng_cnt <= eng_cnt + 1;
                if (eng_cnt == eng_lat_q - 1) begin
                    eng_done <= 1'b1;
                    eng_run  <= 1'b0;
                end
            end
        end
    end

    int clears = 0;
    int loads  = 0;
    always @(negedge clk) begin
        if (eng_clear_hash) clears <= clears + 1;
        if (eng_load) loads <= loads + 1;
    end

    int   checks   = 0;
    int   failures = 0;
    msg_t tbl [NMSG];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " blk_ready"}, blk_ready, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " dig_valid"}, dig_valid, 0);
        chk({tag, " eng_load"}, eng_load, 0);
        chk({tag, " eng_clear_hash"}, eng_clear_hash, 0);
        chk({tag, " error"}, error, 0);
        chk({tag, " blk_count"}, blk_count, 0);
        chk({tag, " eng_block"}, eng_block, 0);
        chk({tag, " eng_prev_hash"}, eng_prev_hash, IV);
        chk({tag, " digest"}, digest, IV);
    endtask

    task automatic run_msg(input int idx, input int stall, input logic keep_valid);
        logic [255:0] chain;
        logic last;
        int c0, l0, k, nb;
        chain = IV;
        c0 = clears;
        l0 = loads;
        nb = tbl[idx].nblk;
        for (int b = 0; b < nb; b++) begin
            last      = (b == nb - 1);
            blk_valid = 1'b1;
            blk_data  = tbl[idx].blk[b];
            blk_last  = last;
            eng_lat   = $urandom_range(64, 68);
            k = 0;
            while (!blk_ready && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            chk("accept ready", blk_ready, 1);
            @(posedge clk); #1;
            if (last) blk_valid = keep_valid;
            chk("eng_load pulse", eng_load, 1);
            chk("eng_clear_hash", eng_clear_hash, b == 0);
            chk("eng_block", eng_block, tbl[idx].blk[b]);
            chk("eng_prev_hash", eng_prev_hash, chain);
            chain = sha_compress(chain, tbl[idx].blk[b]);
            @(posedge clk); #1;
            chk("eng_load one cycle", eng_load, 0);
            k = 2;
            while (!(last ? dig_valid : blk_ready) && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            chk("completion latency", k, 3 + eng_lat);
        end
        for (int s = 0; s < stall; s++) begin
            chk("stall dig_valid", dig_valid, 1);
            chk("stall blk_ready", blk_ready, 0);
            chk("stall digest", digest, tbl[idx].exp);
            @(posedge clk); #1;
        end
        chk("digest", digest, tbl[idx].exp);
        chk("dig_valid", dig_valid, 1);
        chk("blk_count", blk_count, nb);
        chk("clear pulses", clears - c0, 1);
        chk("load pulses", loads - l0, nb);
        chk("error", error, 0);
        dig_ready = 1'b1;
        @(posedge clk); #1;
        dig_ready = 1'b0;
        chk("digest taken", dig_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] tmp;
        logic [255:0] ch, hx, hy;
        int k;
        n_rst = 1'b0;
        blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0; dig_ready = 1'b0;
        blk_valid2 = 1'b0; blk_data2 = '0; blk_last2 = 1'b0; dig_ready2 = 1'b0;
        eng_done2 = 1'b0; eng_hash_out2 = '0;

        tbl[0].nblk = 1;
        tbl[0].blk  = '0;
        tbl[0].blk[0] = {32'h61626380, 416'h0, 64'h18};
        tbl[0].exp  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        tbl[1].nblk = 2;
        tbl[1].blk  = '0;
        tbl[1].blk[0] = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        tbl[1].blk[1] = {448'h0, 64'h1c0};
        tbl[1].exp  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
        for (int i = 2; i < NMSG; i++) begin
            tbl[i].nblk = $urandom_range(1, 3);
            tbl[i].blk  = '0;
            ch = IV;
            for (int b = 0; b < tbl[i].nblk; b++) begin
                tbl[i].blk[b] = rand_blk();
                ch = sha_compress(ch, tbl[i].blk[b]);
            end
            tbl[i].exp = ch;
        end

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Messages run back to back with blk_valid held high; first digest stalls 10 cycles.
        for (int i = 0; i < NMSG; i++) begin
            run_msg(i, (i == 0) ? 10 : int'($urandom_range(0, 3)), (i + 1 < NMSG));
        end

        // Reset on the 30th RUN cycle of block 1 of the two-block message.
        blk_valid = 1'b1; blk_data = tbl[1].blk[0]; blk_last = 1'b0; eng_lat = 80;
        k = 0;
        while (!blk_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        chk("mid-run busy", busy, 1);
        n_rst = 1'b0;
        #1;
        chk_reset("reset async");
        @(posedge clk); #1;
        chk_reset("reset held");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        run_msg(0, 0, 1'b0);

        // Timeout on the stubbed instance (TIMEOUT=16).
        eng_done2 = 1'b0;
        blk_valid2 = 1'b1; blk_data2 = rand_blk(); blk_last2 = 1'b0;
        chk("to ready", blk_ready2, 1);
        @(posedge clk); #1;
        blk_valid2 = 1'b0;
        chk("to load", eng_load2, 1);
        repeat (16) @(posedge clk);
        #1;
        chk("to error before", error2, 0);
        chk("to busy before", busy2, 1);
        @(posedge clk); #1;
        chk("to error", error2, 1);
        chk("to busy", busy2, 0);
        chk("to blk_ready", blk_ready2, 1);
        chk("to dig_valid", dig_valid2, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("to error sticky", error2, 1);

        // Stale done held high: chain must move only after the first RUN cycle.
        eng_done2 = 1'b1;
        tmp = rand_blk(); hx = tmp[255:0];
        tmp = rand_blk(); hy = tmp[255:0];
        eng_hash_out2 = hx;
        blk_valid2 = 1'b1; blk_data2 = rand_blk(); blk_last2 = 1'b0;
        @(posedge clk); #1;
        blk_valid2 = 1'b0;
        chk("error cleared", error2, 0);
        chk("stale clear_hash 1", eng_clear_hash2, 1);
        for (int c = 1; c <= 4; c++) begin
            chk("stale chain b1", eng_prev_hash2, (c < 4) ? IV : hx);
            chk("stale count b1", blk_count2, (c < 4) ? 0 : 1);
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        chk("stale ready b1", blk_ready2, 1);
        eng_hash_out2 = hy;
        blk_valid2 = 1'b1; blk_data2 = rand_blk(); blk_last2 = 1'b1;
        @(posedge clk); #1;
        blk_valid2 = 1'b0;
        chk("stale clear_hash 2", eng_clear_hash2, 0);
        for (int c = 1; c <= 4; c++) begin
            chk("stale chain b2", eng_prev_hash2, (c < 4) ? hx : hy);
            chk("stale count b2", blk_count2, (c < 4) ? 1 : 2);
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        chk("stale dig_valid", dig_valid2, 1);
        chk("stale digest", digest2, hy);
        dig_ready2 = 1'b1;
        @(posedge clk); #1;
        dig_ready2 = 1'b0;
        chk("stale digest taken", dig_valid2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
